// File: rtl/eth_rx_pkg.sv
// Shared definitions for the GMII receive path: parser state encoding, protocol
// constants, header lengths, host command opcodes and the CRC-32 residue.
package eth_rx_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_ETH_HDR,
        S_IP_HDR,
        S_UDP_HDR,
        S_PAYLOAD,
        S_PAD,
        S_DROP
    } rx_state_t;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
    localparam logic [7:0]  IP_VER_IHL5    = 8'h45;
    localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
    localparam logic [7:0]  SFD_BYTE       = 8'hd5;

    localparam int ETH_HDR_LEN = 14;
    localparam int IP_HDR_LEN  = 20;
    localparam int UDP_HDR_LEN = 8;

    localparam logic [7:0]  CMD_SET     = 8'h01;
    localparam logic [7:0]  CMD_RESET   = 8'h02;
    localparam logic [31:0] CRC_RESIDUE = 32'hc704dd7b;

    // Wire-order byte selection: index 0 is the most significant byte.
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
        logic [47:0] sh;
        sh = mac << {idx, 3'b000};
        return sh[47:40];
    endfunction

    function automatic logic [7:0] ip_byte(input logic [31:0] ip, input logic [1:0] idx);
        logic [31:0] sh;
        sh = ip << {idx, 3'b000};
        return sh[31:24];
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide CRC-32 update (IEEE 802.3 polynomial, reflected, LSB of the byte first).
module crc32_d8 (
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    localparam logic [31:0] POLY_REFL = 32'hedb88320;

    logic [31:0] c;

    always_comb begin
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = {1'b0, c[31:1]} ^ POLY_REFL;
            else                c = {1'b0, c[31:1]};
        end
        crc_out = c;
    end

endmodule

// File: rtl/udp_cmd_rx.sv
// GMII UDP receiver: header parse/filter, payload streaming and threshold command decode.
// Optional FCS checking is built when UDP_RX_FCS_CHECK_EN is defined.
module udp_cmd_rx #(
    parameter logic [47:0] LOCAL_MAC      = 48'h00_0a_35_01_fe_c0,
    parameter logic [31:0] LOCAL_IP       = 32'hc0_a8_00_02,
    parameter logic [15:0] LOCAL_UDP_PORT = 16'd5000,
    parameter logic [7:0]  THRESH_INIT    = 8'd128
) (
    input  logic       clk_eth,
    input  logic       rst_n,
    input  logic       gmii_rx_dv,
    input  logic       gmii_rx_er,
    input  logic [7:0] gmii_rx_data,
    output logic [7:0] udp_data,
    output logic       udp_valid,
    output logic       udp_sof,
    output logic       udp_eof,
    output logic       frame_done,
    output logic       frame_err,
    output logic [7:0] threshold,
    output logic       threshold_update
);

    import eth_rx_pkg::*;

    rx_state_t   state, state_n;
    logic [4:0]  cnt, cnt_n;
    logic [15:0] pay_cnt, pay_cnt_n;
    logic [15:0] udp_len, udp_len_n;
    logic        da_local_ok, da_local_n, da_bcast_ok, da_bcast_n;
    logic        for_us, for_us_n;
    logic [7:0]  op, op_n, arg, arg_n;
    logic        hdr_ok, lo_ok, bc_ok;

    logic [7:0]  data_p1, data_n;
    logic        vld_p1, vld_n, sof_p1, sof_n, eof_p1, eof_n;
    logic        done_n, err_n, upd_n;
    logic        abort_er, abort_dv, set_ok, rst_ok, fcs_ok;
    logic [7:0]  pending;

    assign abort_er = gmii_rx_dv && gmii_rx_er && (state != S_DROP);
    assign abort_dv = !gmii_rx_dv &&
                      (state inside {S_PREAMBLE, S_ETH_HDR, S_IP_HDR, S_UDP_HDR, S_PAYLOAD});

    // Command is judged on the full frame: SET needs the arg byte, RESET only the opcode.
    assign set_ok  = (op == CMD_SET)   && (udp_len >= 16'(UDP_HDR_LEN + 2));
    assign rst_ok  = (op == CMD_RESET) && (udp_len >= 16'(UDP_HDR_LEN + 1));
    assign pending = set_ok ? arg : THRESH_INIT;

`ifdef UDP_RX_FCS_CHECK_EN
    logic [31:0] crc, crc_next, crc_rev;

    crc32_d8 u_crc32_d8 (
        .crc_in  (crc),
        .data    (gmii_rx_data),
        .crc_out (crc_next)
    );

    always_ff @(posedge clk_eth or negedge rst_n) begin
        if (!rst_n)                   crc <= '1;
        else if (state == S_PREAMBLE) crc <= '1;
        else if (gmii_rx_dv && (state inside {S_ETH_HDR, S_IP_HDR, S_UDP_HDR, S_PAYLOAD, S_PAD}))
            crc <= crc_next;
    end

    // The register runs bit-reflected; the residue constant is in normal bit order.
    always_comb begin
        for (int i = 0; i < 32; i++) crc_rev[i] = crc[31 - i];
    end

    assign fcs_ok = (crc_rev == CRC_RESIDUE);
`else
    assign fcs_ok = 1'b1;
`endif

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        pay_cnt_n  = pay_cnt;
        udp_len_n  = udp_len;
        da_local_n = da_local_ok;
        da_bcast_n = da_bcast_ok;
        for_us_n   = for_us;
        op_n       = op;
        arg_n      = arg;
        data_n     = data_p1;
        vld_n      = 1'b0;
        sof_n      = 1'b0;
        eof_n      = 1'b0;
        done_n     = 1'b0;
        err_n      = 1'b0;
        upd_n      = 1'b0;
        hdr_ok     = 1'b1;
        lo_ok      = 1'b0;
        bc_ok      = 1'b0;

        if (abort_er) begin
            err_n   = for_us;
            state_n = S_DROP;
        end else if (abort_dv) begin
            err_n   = for_us;
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt_n      = 5'd1;
                    pay_cnt_n  = '0;
                    udp_len_n  = '0;
                    da_local_n = 1'b1;
                    da_bcast_n = 1'b1;
                    for_us_n   = 1'b0;
                    op_n       = '0;
                    arg_n      = '0;
                    if (gmii_rx_dv)
                        state_n = (gmii_rx_data == PREAMBLE_BYTE) ? S_PREAMBLE : S_DROP;
                end
                S_PREAMBLE: begin
                    if (gmii_rx_data == PREAMBLE_BYTE) begin
                        if (cnt == 5'd7) state_n = S_DROP;
                        else             cnt_n   = cnt + 5'd1;
                    end else if (gmii_rx_data == SFD_BYTE) begin
                        state_n = S_ETH_HDR;
                        cnt_n   = '0;
                    end else begin
                        state_n = S_DROP;
                    end
                end
                S_ETH_HDR: begin
                    cnt_n = cnt + 5'd1;
                    if (cnt < 5'd6) begin
                        lo_ok      = da_local_ok && (gmii_rx_data == mac_byte(LOCAL_MAC, cnt[2:0]));
                        bc_ok      = da_bcast_ok && (gmii_rx_data == 8'hff);
                        da_local_n = lo_ok;
                        da_bcast_n = bc_ok;
                        hdr_ok     = lo_ok || bc_ok;
                    end
                    if (cnt == 5'd12 && gmii_rx_data != ETHERTYPE_IPV4[15:8]) hdr_ok = 1'b0;
                    if (cnt == 5'd13 && gmii_rx_data != ETHERTYPE_IPV4[7:0])  hdr_ok = 1'b0;
                    if (!hdr_ok) begin
                        state_n = S_DROP;
                    end else if (cnt == 5'(ETH_HDR_LEN - 1)) begin
                        state_n = S_IP_HDR;
                        cnt_n   = '0;
                    end
                end
                S_IP_HDR: begin
                    cnt_n = cnt + 5'd1;
                    if (cnt == 5'd0 && gmii_rx_data != IP_VER_IHL5)  hdr_ok = 1'b0;
                    if (cnt == 5'd9 && gmii_rx_data != IP_PROTO_UDP) hdr_ok = 1'b0;
                    if (cnt >= 5'd16 && gmii_rx_data != ip_byte(LOCAL_IP, cnt[1:0])) hdr_ok = 1'b0;
                    if (!hdr_ok) begin
                        state_n = S_DROP;
                    end else if (cnt == 5'(IP_HDR_LEN - 1)) begin
                        state_n = S_UDP_HDR;
                        cnt_n   = '0;
                    end
                end
                S_UDP_HDR: begin
                    cnt_n = cnt + 5'd1;
                    if (cnt == 5'd2 && gmii_rx_data != LOCAL_UDP_PORT[15:8]) state_n = S_DROP;
                    if (cnt == 5'd3) begin
                        if (gmii_rx_data != LOCAL_UDP_PORT[7:0]) state_n  = S_DROP;
                        else                                     for_us_n = 1'b1;
                    end
                    if (cnt == 5'd4) udp_len_n[15:8] = gmii_rx_data;
                    if (cnt == 5'd5) udp_len_n[7:0]  = gmii_rx_data;
                    if (cnt == 5'(UDP_HDR_LEN - 1)) begin
                        cnt_n = '0;
                        if (udp_len < 16'(UDP_HDR_LEN)) begin
                            err_n   = 1'b1;
                            state_n = S_DROP;
                        end else if (udp_len == 16'(UDP_HDR_LEN)) begin
                            state_n = S_PAD;
                        end else begin
                            pay_cnt_n = udp_len - 16'(UDP_HDR_LEN);
                            state_n   = S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    vld_n     = 1'b1;
                    data_n    = gmii_rx_data;
                    sof_n     = (cnt == 5'd0);
                    eof_n     = (pay_cnt == 16'd1);
                    pay_cnt_n = pay_cnt - 16'd1;
                    if (cnt == 5'd0) op_n  = gmii_rx_data;
                    if (cnt == 5'd1) arg_n = gmii_rx_data;
                    if (cnt < 5'd2)  cnt_n = cnt + 5'd1;
                    if (pay_cnt == 16'd1) state_n = S_PAD;
                end
                S_PAD: begin
                    if (!gmii_rx_dv) begin
                        state_n = S_IDLE;
                        if (fcs_ok) begin
                            done_n = 1'b1;
                            upd_n  = set_ok || rst_ok;
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                end
                S_DROP: begin
                    if (!gmii_rx_dv) state_n = S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_eth or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            pay_cnt     <= '0;
            udp_len     <= '0;
            da_local_ok <= 1'b0;
            da_bcast_ok <= 1'b0;
            for_us      <= 1'b0;
            op          <= '0;
            arg         <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            pay_cnt     <= pay_cnt_n;
            udp_len     <= udp_len_n;
            da_local_ok <= da_local_n;
            da_bcast_ok <= da_bcast_n;
            for_us      <= for_us_n;
            op          <= op_n;
            arg         <= arg_n;
        end
    end

    // Output stage p1: payload byte and event pulses one clk_eth after the input byte.
    always_ff @(posedge clk_eth or negedge rst_n) begin
        if (!rst_n) begin
            data_p1          <= '0;
            vld_p1           <= 1'b0;
            sof_p1           <= 1'b0;
            eof_p1           <= 1'b0;
            frame_done       <= 1'b0;
            frame_err        <= 1'b0;
            threshold_update <= 1'b0;
            threshold        <= THRESH_INIT;
        end else begin
            data_p1          <= data_n;
            vld_p1           <= vld_n;
            sof_p1           <= sof_n;
            eof_p1           <= eof_n;
            frame_done       <= done_n;
            frame_err        <= err_n;
            threshold_update <= upd_n;
            if (upd_n) threshold <= pending;
        end
    end

    assign udp_data  = data_p1;
    assign udp_valid = vld_p1;
    assign udp_sof   = sof_p1;
    assign udp_eof   = eof_p1;

endmodule

// File: tb/tb_udp_cmd_rx.sv
// Directed bench for udp_cmd_rx: table of complete frames plus hand-written
// truncation, rx_er, bad length and asynchronous reset sequences.
module tb_udp_cmd_rx;

    localparam logic [47:0] MAC  = 48'h000a3501fec0;
    localparam logic [47:0] BC   = 48'hffffffffffff;
    localparam logic [31:0] IP   = 32'hc0a80002;
    localparam logic [15:0] PORT = 16'd5000;
    localparam logic [15:0] ET   = 16'h0800;

    logic       clk_eth = 1'b0;
    logic       rst_n = 1'b0;
    logic       gmii_rx_dv = 1'b0;
    logic       gmii_rx_er = 1'b0;
    logic [7:0] gmii_rx_data = 8'h00;
    logic [7:0] udp_data;
    logic       udp_valid, udp_sof, udp_eof, frame_done, frame_err, threshold_update;
    logic [7:0] threshold;

    udp_cmd_rx dut (
        .clk_eth          (clk_eth),
        .rst_n            (rst_n),
        .gmii_rx_dv       (gmii_rx_dv),
        .gmii_rx_er       (gmii_rx_er),
        .gmii_rx_data     (gmii_rx_data),
        .udp_data         (udp_data),
        .udp_valid        (udp_valid),
        .udp_sof          (udp_sof),
        .udp_eof          (udp_eof),
        .frame_done       (frame_done),
        .frame_err        (frame_err),
        .threshold        (threshold),
        .threshold_update (threshold_update)
    );

    always #4 clk_eth = ~clk_eth;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Output event monitor; only this process writes the m_* counters.
    int m_valid = 0, m_sof = 0, m_eof = 0, m_done = 0, m_err = 0, m_upd = 0;
    logic [7:0] m_first = 8'h00, m_last = 8'h00;
    int b_valid, b_sof, b_eof, b_done, b_err, b_upd;

    always @(posedge clk_eth) begin
        #1;
        if (udp_valid)        begin m_valid++; m_last = udp_data; end
        if (udp_sof)          begin m_sof++;   m_first = udp_data; end
        if (udp_eof)          m_eof++;
        if (frame_done)       m_done++;
        if (frame_err)        m_err++;
        if (threshold_update) m_upd++;
    end

    task automatic snap();
        b_valid = m_valid; b_sof = m_sof; b_eof = m_eof;
        b_done = m_done; b_err = m_err; b_upd = m_upd;
    endtask

    task automatic check_counts(input string tag, input int ev, input int es, input int ee,
                                input int ed, input int er, input int eu);
        check({tag, "_valid"}, m_valid - b_valid, ev);
        check({tag, "_sof"},   m_sof - b_sof,     es);
        check({tag, "_eof"},   m_eof - b_eof,     ee);
        check({tag, "_done"},  m_done - b_done,   ed);
        check({tag, "_err"},   m_err - b_err,     er);
        check({tag, "_upd"},   m_upd - b_upd,     eu);
    endtask

    // Frame construction
    logic [7:0] frame_q[$];
    int pre_n = 7;
    int hdr0 = 8;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hedb88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    task automatic build(input logic [47:0] da, input logic [31:0] ip, input logic [15:0] port,
                         input logic [15:0] et, input int plen, input logic [7:0] p0,
                         input logic [7:0] p1, input bit bad_fcs, input int len_ovr);
        logic [15:0] ulen, tlen;
        logic [31:0] crc;
        ulen = (len_ovr >= 0) ? 16'(len_ovr) : 16'(8 + plen);
        tlen = 16'd20 + ulen;
        frame_q.delete();
        for (int i = 0; i < pre_n; i++) frame_q.push_back(8'h55);
        frame_q.push_back(8'hd5);
        hdr0 = frame_q.size();
        for (int i = 5; i >= 0; i--) frame_q.push_back(da[8*i +: 8]);
        for (int i = 0; i < 6; i++) frame_q.push_back(8'(8'h10 + i));
        frame_q.push_back(et[15:8]); frame_q.push_back(et[7:0]);
        frame_q.push_back(8'h45); frame_q.push_back(8'h00);
        frame_q.push_back(tlen[15:8]); frame_q.push_back(tlen[7:0]);
        frame_q.push_back(8'h00); frame_q.push_back(8'h00);
        frame_q.push_back(8'h40); frame_q.push_back(8'h00);
        frame_q.push_back(8'h40); frame_q.push_back(8'h11);
        frame_q.push_back(8'h00); frame_q.push_back(8'h00);
        frame_q.push_back(8'hc0); frame_q.push_back(8'ha8);
        frame_q.push_back(8'h00); frame_q.push_back(8'h01);
        for (int i = 3; i >= 0; i--) frame_q.push_back(ip[8*i +: 8]);
        frame_q.push_back(8'h04); frame_q.push_back(8'hd2);
        frame_q.push_back(port[15:8]); frame_q.push_back(port[7:0]);
        frame_q.push_back(ulen[15:8]); frame_q.push_back(ulen[7:0]);
        frame_q.push_back(8'h00); frame_q.push_back(8'h00);
        for (int i = 0; i < plen; i++)
            frame_q.push_back((i == 0) ? p0 : (i == 1) ? p1 : 8'(i));
        while (frame_q.size() < hdr0 + 60) frame_q.push_back(8'h00);
        crc = 32'hffffffff;
        for (int i = hdr0; i < frame_q.size(); i++) crc = crc_byte(crc, frame_q[i]);
        crc = ~crc;
        if (bad_fcs) crc[5] = ~crc[5];
        for (int i = 0; i < 4; i++) frame_q.push_back(crc[8*i +: 8]);
    endtask

    task automatic send(input int nbytes, input int er_at);
        for (int i = 0; i < nbytes; i++) begin
            @(negedge clk_eth);
            gmii_rx_dv   = 1'b1;
            gmii_rx_er   = (i == er_at);
            gmii_rx_data = frame_q[i];
        end
    endtask

    task automatic end_frame();
        @(negedge clk_eth);
        gmii_rx_dv   = 1'b0;
        gmii_rx_er   = 1'b0;
        gmii_rx_data = 8'h00;
    endtask

    task automatic settle();
        repeat (3) @(posedge clk_eth);
        #2;
    endtask

    typedef struct {
        logic [47:0] da;
        logic [31:0] ip;
        logic [15:0] port;
        logic [15:0] et;
        int          plen;
        logic [7:0]  p0;
        logic [7:0]  p1;
        bit          bad;
        int          e_valid, e_sof, e_eof, e_done, e_err, e_upd;
        logic [7:0]  e_thr;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_last, thr8;
        vec_t v;

`ifdef UDP_RX_FCS_CHECK_EN
        thr8 = 8'h80;
`else
        thr8 = 8'h22;
`endif
        vecs[0]  = '{MAC, IP, PORT, ET, 2, 8'h01, 8'h3c, 0, 2, 1, 1, 1, 0, 1, 8'h3c};
        vecs[1]  = '{MAC, IP, 16'd5001, ET, 2, 8'h01, 8'h11, 0, 0, 0, 0, 0, 0, 0, 8'h3c};
        vecs[2]  = '{MAC, 32'hc0a80009, PORT, ET, 2, 8'h01, 8'h11, 0, 0, 0, 0, 0, 0, 0, 8'h3c};
        vecs[3]  = '{MAC, IP, PORT, 16'h0806, 2, 8'h01, 8'h11, 0, 0, 0, 0, 0, 0, 0, 8'h3c};
        vecs[4]  = '{BC, IP, PORT, ET, 1, 8'h02, 8'h00, 0, 1, 1, 1, 1, 0, 1, 8'h80};
        vecs[5]  = '{MAC, IP, PORT, ET, 2, 8'h07, 8'h55, 0, 2, 1, 1, 1, 0, 0, 8'h80};
        vecs[6]  = '{MAC, IP, PORT, ET, 2, 8'h01, 8'h80, 0, 2, 1, 1, 1, 0, 1, 8'h80};
        vecs[7]  = '{MAC, IP, PORT, ET, 1, 8'h01, 8'h00, 0, 1, 1, 1, 1, 0, 0, 8'h80};
`ifdef UDP_RX_FCS_CHECK_EN
        vecs[8]  = '{MAC, IP, PORT, ET, 2, 8'h01, 8'h22, 1, 2, 1, 1, 0, 1, 0, 8'h80};
`else
        vecs[8]  = '{MAC, IP, PORT, ET, 2, 8'h01, 8'h22, 1, 2, 1, 1, 1, 0, 1, 8'h22};
`endif
        vecs[9]  = '{MAC, IP, PORT, ET, 0, 8'h01, 8'h99, 0, 0, 0, 0, 1, 0, 0, thr8};
        vecs[10] = '{48'h000a3501fec1, IP, PORT, ET, 2, 8'h01, 8'h11, 0, 0, 0, 0, 0, 0, 0, thr8};
        vecs[11] = '{MAC, IP, PORT, ET, 3, 8'h01, 8'h3c, 0, 3, 1, 1, 1, 0, 1, 8'h3c};
        vecs[12] = '{MAC, IP, PORT, ET, 2, 8'h02, 8'h44, 0, 2, 1, 1, 1, 0, 1, 8'h80};
        vecs[13] = '{MAC, IP, PORT, ET, 2, 8'h01, 8'h3c, 0, 2, 1, 1, 1, 0, 1, 8'h3c};

        // Reset state
        repeat (3) @(posedge clk_eth);
        #1;
        check("rst_udp_valid", udp_valid, 0);
        check("rst_udp_sof", udp_sof, 0);
        check("rst_udp_eof", udp_eof, 0);
        check("rst_udp_data", udp_data, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_thr_update", threshold_update, 0);
        check("rst_threshold", threshold, 8'd128);
        @(negedge clk_eth);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_eth);

        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            build(v.da, v.ip, v.port, v.et, v.plen, v.p0, v.p1, v.bad, -1);
            snap();
            send(frame_q.size(), -1);
            end_frame();
            @(posedge clk_eth);
            #1;
            check($sformatf("v%0d_done_at_dvfall", i), frame_done, v.e_done);
            check($sformatf("v%0d_upd_at_dvfall", i), threshold_update, v.e_upd);
            settle();
            check_counts($sformatf("v%0d", i), v.e_valid, v.e_sof, v.e_eof, v.e_done, v.e_err, v.e_upd);
            check($sformatf("v%0d_threshold", i), threshold, v.e_thr);
            if (v.e_sof != 0) begin
                exp_last = (v.plen == 1) ? v.p0 : (v.plen == 2) ? v.p1 : 8'(v.plen - 1);
                check($sformatf("v%0d_first_byte", i), m_first, v.p0);
                check($sformatf("v%0d_last_byte", i), m_last, exp_last);
            end
        end

        // Short (1 byte) and over-long (8 byte) preamble
        pre_n = 1;
        build(MAC, IP, PORT, ET, 2, 8'h01, 8'h21, 0, -1);
        snap(); send(frame_q.size(), -1); end_frame(); settle();
        check_counts("pre1", 2, 1, 1, 1, 0, 1);
        check("pre1_threshold", threshold, 8'h21);
        pre_n = 8;
        build(MAC, IP, PORT, ET, 2, 8'h01, 8'h31, 0, -1);
        snap(); send(frame_q.size(), -1); end_frame(); settle();
        check_counts("pre8", 0, 0, 0, 0, 0, 0);
        check("pre8_threshold", threshold, 8'h21);
        pre_n = 7;

        // Truncated after one payload byte, then a frame after a one-cycle gap
        build(MAC, IP, PORT, ET, 2, 8'h01, 8'h44, 0, -1);
        snap();
        send(hdr0 + 43, -1);
        end_frame();
        @(posedge clk_eth);
        #1;
        check("trunc_err_pulse", frame_err, 1);
        check_counts("trunc", 1, 1, 0, 0, 1, 0);
        check("trunc_threshold", threshold, 8'h21);
        build(MAC, IP, PORT, ET, 2, 8'h01, 8'h5a, 0, -1);
        snap(); send(frame_q.size(), -1); end_frame(); settle();
        check_counts("b2b", 2, 1, 1, 1, 0, 1);
        check("b2b_threshold", threshold, 8'h5a);

        // rx_er on the second payload byte
        build(MAC, IP, PORT, ET, 2, 8'h01, 8'h66, 0, -1);
        snap(); send(frame_q.size(), hdr0 + 43); end_frame(); settle();
        check_counts("rxer", 1, 1, 0, 0, 1, 0);
        check("rxer_threshold", threshold, 8'h5a);

        // rx_er before the port match stays silent
        build(MAC, IP, PORT, ET, 2, 8'h01, 8'h66, 0, -1);
        snap(); send(frame_q.size(), hdr0 + 20); end_frame(); settle();
        check_counts("rxer_early", 0, 0, 0, 0, 0, 0);

        // UDP length below the header size
        build(MAC, IP, PORT, ET, 2, 8'h01, 8'h67, 0, 4);
        snap(); send(frame_q.size(), -1); end_frame(); settle();
        check_counts("shortlen", 0, 0, 0, 0, 1, 0);
        check("shortlen_threshold", threshold, 8'h5a);

        // Asynchronous reset mid-payload
        build(MAC, IP, PORT, ET, 2, 8'h01, 8'h77, 0, -1);
        send(hdr0 + 43, -1);
        @(posedge clk_eth);
        #2;
        check("midrst_valid_before", udp_valid, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", udp_valid, 0);
        check("midrst_sof", udp_sof, 0);
        check("midrst_data", udp_data, 0);
        check("midrst_threshold", threshold, 8'd128);
        end_frame();
        repeat (2) @(negedge clk_eth);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_eth);
        build(MAC, IP, PORT, ET, 2, 8'h01, 8'h11, 0, -1);
        snap(); send(frame_q.size(), -1); end_frame(); settle();
        check_counts("postrst", 2, 1, 1, 1, 0, 1);
        check("postrst_threshold", threshold, 8'h11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
